// File: rtl/seg7_scan32.sv
// seg7_scan32 - multiplexed 8-digit hexadecimal 7-segment display driver.
//
// Shows a 32-bit value as eight hex digits on one shared segment bus,
// strobing one anode per digit slot. A snapshot taken on `load` is held in
// a shadow register. It moves to the display register only at a frame
// boundary, so a single frame never mixes two values. Each slot opens with
// a guard interval that keeps all anodes off, which suppresses ghosting
// while the segment bus changes.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   value[31:0] value to display; nibble i -> digit i, digit 0 rightmost
//   load        sample `value` into the shadow register on this edge
//   blank_lz    enable leading-zero blanking
//   dp_in[7:0]  decimal point request per digit, active high
//   seg[6:0]    {g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW_SEG
//   dp          decimal point pin, same polarity as seg
//   an[7:0]     one-hot digit enable, polarity set by ACTIVE_LOW_AN
//   frame_done  one-cycle pulse after the last slot of each frame
module seg7_scan32 #(
  parameter int REFRESH_DIV    = 50000,  // cycles per digit slot, >= 2
  parameter int GUARD          = 16,     // anode-off cycles per slot, < REFRESH_DIV
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [7:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_done
);

  localparam int             PW       = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]  PCNT_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_OFF  = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic           DP_OFF   = ACTIVE_LOW_SEG;
  localparam logic [7:0]     AN_OFF   = ACTIVE_LOW_AN ? 8'hFF : 8'h00;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h3F;
      4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;
      4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;
      4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;
      4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;
      4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    didx_q, didx_d;
  logic [31:0]   shd_q, shd_d;
  logic [31:0]   disp_q, disp_d;
  logic          frame_done_q, frame_done_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [7:0]    an_q, an_d;

  logic          tick, wrap, blank, in_guard;
  logic [3:0]    nib;
  logic [31:0]   upper;
  logic [6:0]    seg_hi;
  logic          dp_hi;
  logic [7:0]    an_hi;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    pcnt_d       = pcnt_q + 1'b1;
    didx_d       = didx_q;
    shd_d        = shd_q;
    disp_d       = disp_q;

    tick         = (pcnt_q == PCNT_MAX);
    wrap         = tick && (didx_q == 3'd7);

    if (tick) begin
      pcnt_d = '0;
      didx_d = didx_q + 3'd1;  // 7 -> 0 wraps naturally
    end

    if (load) shd_d = value;
    // A load coinciding with the frame boundary bypasses the shadow, so the
    // newest value is never lost behind a stale snapshot.
    if (wrap) disp_d = load ? value : shd_q;

    frame_done_d = wrap;

    // Display path reads the current state; the output register adds the
    // single cycle of pin latency.
    nib      = disp_q[{didx_q, 2'b00} +: 4];
    upper    = disp_q >> {didx_q, 2'b00};
    blank    = blank_lz && (didx_q != 3'd0) && (upper == 32'd0);
    in_guard = (32'(pcnt_q) < GUARD);

    seg_hi   = blank ? 7'h00 : hex_decode(nib);
    dp_hi    = !blank && dp_in[didx_q];
    an_hi    = in_guard ? 8'h00 : (8'd1 << didx_q);

    seg_d    = ACTIVE_LOW_SEG ? ~seg_hi : seg_hi;
    dp_d     = ACTIVE_LOW_SEG ? ~dp_hi  : dp_hi;
    an_d     = ACTIVE_LOW_AN  ? ~an_hi  : an_hi;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q       <= '0;
      didx_q       <= '0;
      shd_q        <= '0;
      disp_q       <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
    end else begin
      pcnt_q       <= pcnt_d;
      didx_q       <= didx_d;
      shd_q        <= shd_d;
      disp_q       <= disp_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan32.sv
// tb_seg7_scan32 - self-checking bench for seg7_scan32 with REFRESH_DIV=4,
// GUARD=1 and active-low pins. A reference model derives every expected pin
// value from the elapsed cycle count since reset (slot = cycle / 4, digit =
// slot mod 8) plus a snapshot/display value pair, and is compared on every
// clock. Directed steps add fixed-constant checks for the display scenarios.
module tb_seg7_scan32;

  localparam int RD    = 4;
  localparam int G     = 1;
  localparam int FRAME = 8 * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        load;
  logic        blank_lz;
  logic [7:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_done;

  seg7_scan32 #(
    .REFRESH_DIV   (RD),
    .GUARD         (G),
    .ACTIVE_LOW_SEG(1'b1),
    .ACTIVE_LOW_AN (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .blank_lz  (blank_lz),
    .dp_in     (dp_in),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int          cyc;     // clock edges since reset release
  logic [31:0] m_shd;
  logic [31:0] m_disp;
  logic [6:0]  hex_tab [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock edge: predict pins from the pre-edge model state, advance the
  // model, then compare just after the edge.
  task automatic step();
    int          d, ph;
    logic        blank;
    logic [3:0]  nib;
    logic [6:0]  xseg;
    logic        xdp;
    logic [7:0]  xan;
    logic        xfd;
    @(posedge clk);
    d     = (cyc / RD) % 8;
    ph    = cyc % RD;
    nib   = 4'((m_disp >> (4 * d)) & 32'hF);
    blank = blank_lz && (d != 0) && ((m_disp >> (4 * d)) == 32'd0);
    xseg  = blank ? 7'h7F : ~hex_tab[nib];
    xdp   = blank ? 1'b1 : ~dp_in[d];
    xan   = (ph < G) ? 8'hFF : ~(8'd1 << d);
    xfd   = ((cyc % FRAME) == FRAME - 1);
    if (xfd) m_disp = load ? value : m_shd;
    if (load) m_shd = value;
    cyc++;
    #1;
    check("seg", {25'd0, seg}, {25'd0, xseg});
    check("dp", {31'd0, dp}, {31'd0, xdp});
    check("an", {24'd0, an}, {24'd0, xan});
    check("frame_done", {31'd0, frame_done}, {31'd0, xfd});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next edge begins a new frame (digit 0, phase 0).
  task automatic goto_frame_start();
    for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != 0; i++) step();
    check("frame_align", cyc % FRAME, 0);
  endtask

  task automatic do_load(input logic [31:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic apply_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_an", {24'd0, an}, 32'hFF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp", {31'd0, dp}, 32'h1);
    check("rst_fd", {31'd0, frame_done}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_an", {24'd0, an}, 32'hFF);
    @(negedge clk);
    rst    = 1'b1;
    cyc    = 0;
    m_shd  = '0;
    m_disp = '0;
  endtask

  initial begin
    logic [6:0] scan_tab [8];
    int         nfd;
    int         d;

    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    scan_tab = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

    rst = 1'b1; value = '0; load = 1'b0; blank_lz = 1'b0; dp_in = '0;
    cyc = 0; m_shd = '0; m_disp = '0;

    // Power-on reset, then the first slot: one guard cycle, three FE cycles.
    @(negedge clk);
    apply_reset();
    step();
    check("first_guard", {24'd0, an}, 32'hFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("first_slot_an", {24'd0, an}, 32'hFE);
    end
    step();
    check("second_slot_guard", {24'd0, an}, 32'hFF);

    // Reset in the middle of a slot, after a value is loaded.
    do_load(32'hDEADBEEF);
    run(FRAME + 5);
    apply_reset();
    step();
    check("post_rst_guard", {24'd0, an}, 32'hFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_an", {24'd0, an}, 32'hFE);
      check("post_rst_seg", {25'd0, seg}, 32'h40);
    end

    // Hex scan of 0x89ABCDEF.
    do_load(32'h89ABCDEF);
    goto_frame_start();
    nfd = 0;
    for (int s = 0; s < 2 * FRAME; s++) begin
      step();
      if (frame_done === 1'b1) nfd++;
      if (s < FRAME && (s % RD) == 1) begin
        check("scan_seg", {25'd0, seg}, {25'd0, scan_tab[s / RD]});
        check("scan_an", {24'd0, an}, {24'd0, ~(8'd1 << (s / RD))});
      end
    end
    check("frame_done_count", nfd, 2);

    // Tear-free load: two loads in one frame, only the last one shows next.
    run(5);
    do_load(32'h11111111);
    run(6);
    do_load(32'h22222222);
    run(3);
    check("tear_cur_seg", {25'd0, seg}, {25'd0, scan_tab[(((cyc - 1) % FRAME) / RD)]});
    goto_frame_start();
    for (int s = 0; s < FRAME; s++) begin
      step();
      if ((s % RD) == 1) check("tear_next_seg", {25'd0, seg}, 32'h24);
    end

    // Load coinciding with the wrap edge goes straight to the display.
    for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != FRAME - 1; i++) step();
    do_load(32'h00000005);
    step();
    check("wrap_load_d0", {25'd0, seg}, 32'h12);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(32'h00000A00);
    goto_frame_start();
    for (int s = 0; s < FRAME; s++) begin
      step();
      if ((s % RD) == 1) begin
        d = s / RD;
        check("lz_an", {24'd0, an}, {24'd0, ~(8'd1 << d)});
        if (d >= 3)      check("lz_blank", {25'd0, seg}, 32'h7F);
        else if (d == 2) check("lz_d2", {25'd0, seg}, 32'h08);
        else             check("lz_zero", {25'd0, seg}, 32'h40);
      end
    end
    do_load(32'h00000000);
    goto_frame_start();
    for (int s = 0; s < FRAME; s++) begin
      step();
      if ((s % RD) == 1) check("lz_all0", {25'd0, seg}, (s < RD) ? 32'h40 : 32'h7F);
    end

    // Decimal points on digits 0 and 2, then a mid-slot toggle.
    blank_lz = 1'b0;
    dp_in    = 8'h05;
    do_load(32'h12345678);
    goto_frame_start();
    for (int s = 0; s < FRAME; s++) begin
      step();
      if ((s % RD) == 1) check("dp_slot", {31'd0, dp}, (s / RD == 0 || s / RD == 2) ? 32'h0 : 32'h1);
    end
    step();
    dp_in = 8'h00;
    step();
    check("dp_toggle_off", {31'd0, dp}, 32'h1);
    dp_in = 8'h01;
    step();
    check("dp_toggle_on", {31'd0, dp}, 32'h0);

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      value    = $urandom;
      if ($urandom_range(0, 3) == 0) value = value >> (4 * $urandom_range(1, 7));
      load     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0)  dp_in    = 8'($urandom);
      step();
      if (i == 300) begin
        load = 1'b0;
        apply_reset();
      end
    end
    load = 1'b0;
    run(FRAME);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
